pipo_rr_arbiter: RTL and testbench

- Controller that shares one W-bit parallel-in/parallel-out register among N requesters.
- Each requester presents a data word and a request. The block grants one requester at a time, in round-robin order, and loads that requester's word into the shared register.
- It then pulses a per-requester acknowledge and reports which requester owns the current contents.
- Sits in front of the register file / PIPO storage in the sequential library. All state updates occur on the rising edge of clk.

---
 rtl/pipo_rr_arbiter.sv | 102 ++++++++++
 tb/tb_pipo_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared W-bit register.
// Three-phase handshake per transfer: IDLE (arbitrate) -> GRANT -> ACK.
module pipo_rr_arbiter #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] d,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   q,
    output logic [IW-1:0]  owner,
    output logic           valid,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    localparam logic [IW:0] NL = (IW+1)'(N);

    state_t         r_state, w_next;
    logic [IW-1:0]  r_ptr, r_sel, r_owner;
    logic [N-1:0]   r_gnt, r_ack;
    logic [W-1:0]   r_q;
    logic           r_valid;

    logic [W-1:0]   w_dw [N];
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off, w_pick, w_nptr;
    logic [IW:0]    w_sum;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_dw[i] = d[i*W +: W];
    end

    // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
    assign w_dbl = {req, req} >> r_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_off = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IW'(k);
        end
    end

    assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_pick = (w_sum >= NL) ? IW'(w_sum - NL) : IW'(w_sum);
    assign w_nptr = (r_sel == IW'(N-1)) ? '0 : r_sel + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (|req) w_next = GRANT;
            GRANT:   w_next = req[r_sel] ? ACK : IDLE;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A granted requester that withdraws before the GRANT closing edge aborts the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_valid <= 1'b0;
        end else begin
            r_gnt <= '0;
            r_ack <= '0;
            if (r_state == IDLE && |req) begin
                r_sel <= w_pick;
                r_gnt <= N'(1) << w_pick;
            end
            if (r_state == GRANT && req[r_sel]) begin
                r_q     <= w_dw[r_sel];
                r_owner <= r_sel;
                r_valid <= 1'b1;
                r_ptr   <= w_nptr;
                r_ack   <= N'(1) << r_sel;
            end
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign q     = r_q;
    assign owner = r_owner;
    assign valid = r_valid;
    assign busy  = (r_state != IDLE);
endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Scoreboard bench for pipo_rr_arbiter: a transaction-level model predicts grants and
// loads; a monitor checks every cycle one edge later.
module tb_pipo_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   q;
    logic [IW-1:0]  owner;
    logic           valid, busy;

    always #5 clk = ~clk;

    pipo_rr_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .d(d),
        .gnt(gnt), .ack(ack), .q(q), .owner(owner), .valid(valid), .busy(busy)
    );

    typedef struct packed {
        logic [N-1:0]  oh;
        logic [W-1:0]  q;
        logic [IW-1:0] own;
    } exp_t;

    exp_t gq[$];
    exp_t aq[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    // Model: phase 0 idle, 1 granted, 2 acknowledging; values describe the state after the next edge.
    int         m_phase, m_ptr, m_sel, m_owner;
    logic [W-1:0] m_q;
    bit         m_valid;
    bit         P [N];
    logic [W-1:0] D [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Closest requester at or after ptr, measured as circular distance.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - ptr + N) % N) < bd) begin
                bd = (i - ptr + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic bit any_pending();
        bit a = 1'b0;
        for (int i = 0; i < N; i++) a |= P[i];
        return a;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_sel = 0; m_owner = 0; m_q = '0; m_valid = 1'b0;
        for (int i = 0; i < N; i++) begin P[i] = 1'b0; D[i] = '0; end
        gq.delete();
        aq.delete();
    endtask

    task automatic cycle(input bit raise, input int abort_pct);
        logic [N-1:0]   rv;
        logic [N*W-1:0] dv;
        @(negedge clk);
        if (m_phase == 2) P[m_sel] = 1'b0;
        if (m_phase == 1 && int'($urandom_range(99)) < abort_pct) P[m_sel] = 1'b0;
        if (raise) begin
            for (int i = 0; i < N; i++) begin
                if (!P[i] && !(m_phase == 1 && i == m_sel) && $urandom_range(3) == 0) begin
                    P[i] = 1'b1;
                    D[i] = W'($urandom);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            rv[i] = P[i];
            dv[i*W +: W] = P[i] ? D[i] : W'($urandom);
        end
        case (m_phase)
            0: if (rv != 0) begin
                m_sel = rr_pick(rv, m_ptr);
                gq.push_back('{oh: N'(1) << m_sel, q: '0, own: '0});
                m_phase = 1;
            end
            1: if (rv[m_sel]) begin
                m_q = D[m_sel];
                m_owner = m_sel;
                m_valid = 1'b1;
                m_ptr = (m_sel + 1) % N;
                aq.push_back('{oh: N'(1) << m_sel, q: D[m_sel], own: IW'(m_sel)});
                m_phase = 2;
            end else m_phase = 0;
            default: m_phase = 0;
        endcase
        req = rv;
        d = dv;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            cycle(1'b0, 0);
            n++;
        end while ((any_pending() || m_phase != 0) && n < 200);
        chk("drain_bound", 32'(n < 200), 32'd1);
        @(posedge clk);
        #2;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (checking) begin
            if (gnt != 0) begin
                if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
                else begin
                    mon_e = gq.pop_front();
                    chk("gnt", 32'(gnt), 32'(mon_e.oh));
                end
            end
            if (gq.size() != 0) begin
                chk("gnt_missing", 32'(gnt), 32'(gq[0].oh));
                gq.delete();
            end
            if (ack != 0) begin
                if (aq.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
                else begin
                    mon_e = aq.pop_front();
                    chk("ack", 32'(ack), 32'(mon_e.oh));
                    chk("ack_q", 32'(q), 32'(mon_e.q));
                    chk("ack_owner", 32'(owner), 32'(mon_e.own));
                end
            end
            if (aq.size() != 0) begin
                chk("ack_missing", 32'(ack), 32'(aq[0].oh));
                aq.delete();
            end
            chk("gnt_ack_overlap", 32'(gnt & ack), 32'd0);
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("q", 32'(q), 32'(m_q));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("valid", 32'(valid), 32'(m_valid));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; d = '0;
        model_reset();
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;

        // All four requesting from ptr=0: order 0,1,2,3.
        for (int i = 0; i < N; i++) begin P[i] = 1'b1; D[i] = W'(i + 1); end
        drain();
        chk("rr_final_q", 32'(q), 32'h4);
        chk("rr_final_owner", 32'(owner), 32'd3);

        // Wrap to ptr=0, then 1 before 3; then ptr=2 makes 0 win over 1.
        P[1] = 1'b1; D[1] = 4'h6; P[3] = 1'b1; D[3] = 4'h8;
        drain();
        chk("wrap_owner", 32'(owner), 32'd3);
        P[1] = 1'b1; D[1] = 4'h2;
        drain();
        P[0] = 1'b1; D[0] = 4'hE; P[1] = 1'b1; D[1] = 4'hF;
        drain();
        chk("fair_owner", 32'(owner), 32'd1);

        // Single request.
        P[2] = 1'b1; D[2] = 4'hA;
        drain();
        chk("single_q", 32'(q), 32'hA);
        chk("single_owner", 32'(owner), 32'd2);
        chk("single_valid", 32'(valid), 32'd1);

        // Abort: requester 0 drops during GRANT.
        P[0] = 1'b1; D[0] = 4'h7;
        cycle(1'b0, 0);
        cycle(1'b0, 100);
        @(posedge clk); #2;
        chk("abort_q", 32'(q), 32'hA);
        chk("abort_owner", 32'(owner), 32'd2);
        chk("abort_busy", 32'(busy), 32'd0);
        P[1] = 1'b1; D[1] = 4'h3;
        drain();
        chk("post_abort_q", 32'(q), 32'h3);

        // Idle hold after a load of C.
        P[3] = 1'b1; D[3] = 4'hC;
        drain();
        repeat (10) cycle(1'b0, 0);
        @(posedge clk); #2;
        chk("idle_q", 32'(q), 32'hC);
        chk("idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset while in GRANT.
        P[0] = 1'b1; D[0] = 4'h5;
        drain();
        P[1] = 1'b1; D[1] = 4'h9;
        cycle(1'b0, 0);
        @(posedge clk); #3;
        chk("pre_arst_gnt", 32'(gnt), 32'h2);
        rst = 1'b1; req = '0;
        model_reset();
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_q", 32'(q), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cycle(1'b0, 0);

        // Randomized traffic with occasional aborts.
        repeat (1500) cycle(1'b1, 10);
        drain();
        chk("gq_empty", 32'(gq.size()), 32'd0);
        chk("aq_empty", 32'(aq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
